// File: rtl/cnt8_cmd_seq_if.sv
// Command handshake bundle between a stimulus source and cnt8_cmd_seq.
// Latency: none (wires only).
// Backpressure: source holds cmd_valid/cmd_op/cmd_len until it sees cmd_ready at a rising edge.
interface cnt8_cmd_seq_if #(
  parameter int LEN_W = 4
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [LEN_W-1:0] cmd_len;

  modport master (output cmd_valid, output cmd_op, output cmd_len, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_len, output cmd_ready);
endinterface

// File: rtl/cnt8_cmd_seq.sv
// Replays opcode/length commands as registered load/inc control runs for the 3-bit counter.
// Latency: first drive cycle one cycle after the accepting edge; done pulses the cycle after the last drive.
// Backpressure: cmd_ready only in IDLE, or whenever the pending slot is empty with CNT8_CMD_PREFETCH_EN.
module cnt8_cmd_seq #(
  parameter int LEN_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  cnt8_cmd_seq_if.slave      cmd,
  input  logic               abort,
  output logic               load,
  output logic               inc,
  output logic               busy,
  output logic               done
);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             done_q, done_d;
  logic             rdy;
  logic             fire;
  logic             last_run;

`ifdef CNT8_CMD_PREFETCH_EN
  logic             pend_vld_q, pend_vld_d;
  logic [1:0]       pend_op_q, pend_op_d;
  logic [LEN_W-1:0] pend_len_q, pend_len_d;
`endif

  // Ready depends only on state/slot, reset and abort, so an aborted cycle never accepts.
  always_comb begin
`ifdef CNT8_CMD_PREFETCH_EN
    rdy = ~reset & ~abort & ~pend_vld_q;
`else
    rdy = ~reset & ~abort & (state_q == S_IDLE);
`endif
  end

  assign cmd.cmd_ready = rdy;
  assign fire          = cmd.cmd_valid & rdy;
  assign last_run      = (state_q == S_RUN) && (rem_q == '0);

  // Next-state logic: accept, count down the run, chain into the next command when possible.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
`ifdef CNT8_CMD_PREFETCH_EN
    pend_vld_d = pend_vld_q;
    pend_op_d  = pend_op_q;
    pend_len_d = pend_len_q;
`endif
    if (abort) begin
      state_d = S_IDLE;
      rem_d   = '0;
`ifdef CNT8_CMD_PREFETCH_EN
      pend_vld_d = 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (fire) begin
            state_d = S_RUN;
            op_d    = cmd.cmd_op;
            rem_d   = cmd.cmd_len;
          end
        end
        S_RUN: begin
          if (last_run) begin
            done_d = 1'b1;
`ifdef CNT8_CMD_PREFETCH_EN
            // Slot full means ready was low, so fire cannot collide with a pending command.
            if (pend_vld_q) begin
              op_d       = pend_op_q;
              rem_d      = pend_len_q;
              pend_vld_d = 1'b0;
            end else if (fire) begin
              op_d  = cmd.cmd_op;
              rem_d = cmd.cmd_len;
            end else begin
              state_d = S_IDLE;
            end
`else
            state_d = S_IDLE;
`endif
          end else begin
            rem_d = rem_q - LEN_W'(1);
`ifdef CNT8_CMD_PREFETCH_EN
            if (fire) begin
              pend_vld_d = 1'b1;
              pend_op_d  = cmd.cmd_op;
              pend_len_d = cmd.cmd_len;
            end
`endif
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= 2'b00;
      rem_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
    end
  end

`ifdef CNT8_CMD_PREFETCH_EN
  // Pending command slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_vld_q <= 1'b0;
      pend_op_q  <= 2'b00;
      pend_len_q <= '0;
    end else begin
      pend_vld_q <= pend_vld_d;
      pend_op_q  <= pend_op_d;
      pend_len_q <= pend_len_d;
    end
  end
`endif

  // Controls come straight from flops: op bit 0 is load, op bit 1 is inc.
  always_comb begin
    busy = (state_q == S_RUN);
    load = (state_q == S_RUN) & op_q[0];
    inc  = (state_q == S_RUN) & op_q[1];
    done = done_q;
  end

endmodule

// File: tb/tb_cnt8_cmd_seq.sv
// Directed self-checking bench for cnt8_cmd_seq.
// Each task drives one scenario and compares outputs one cycle at a time.
// Inputs change 1ns after the rising edge; outputs are checked before the next edge.
module tb_cnt8_cmd_seq;
  logic clk = 1'b0;
  logic reset;
  logic abort;
  logic load, inc, busy, done;
  int   total = 0;
  int   bad   = 0;

  cnt8_cmd_seq_if #(.LEN_W(4)) cif ();

  cnt8_cmd_seq #(.LEN_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .cmd   (cif),
    .abort (abort),
    .load  (load),
    .inc   (inc),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [3:0] len);
    cif.cmd_valid = 1'b1;
    cif.cmd_op    = op;
    cif.cmd_len   = len;
    step();
    cif.cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    total++; if (cif.cmd_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", cif.cmd_ready); end
    total++; if ({load, inc, busy, done} !== 4'b0000) begin bad++; $display("FAIL rst_outs got=%b exp=0000", {load, inc, busy, done}); end
    reset = 1'b0;
    #1;
    total++; if (cif.cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%b exp=1", cif.cmd_ready); end
  endtask

  task automatic test_load0();
    send(2'b01, 4'd0);
    total++; if ({load, inc, busy, done} !== 4'b1010) begin bad++; $display("FAIL load0_drive got=%b exp=1010", {load, inc, busy, done}); end
`ifdef CNT8_CMD_PREFETCH_EN
    total++; if (cif.cmd_ready !== 1'b1) begin bad++; $display("FAIL load0_ready_run got=%b exp=1", cif.cmd_ready); end
`else
    total++; if (cif.cmd_ready !== 1'b0) begin bad++; $display("FAIL load0_ready_run got=%b exp=0", cif.cmd_ready); end
`endif
    step();
    total++; if ({load, inc, busy, done} !== 4'b0001) begin bad++; $display("FAIL load0_done got=%b exp=0001", {load, inc, busy, done}); end
    total++; if (cif.cmd_ready !== 1'b1) begin bad++; $display("FAIL load0_ready_done got=%b exp=1", cif.cmd_ready); end
    step();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL load0_done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_inc4();
    int cnt = 0;
    int busy_cycles = 0;
    int done_cycles = 0;
    send(2'b10, 4'd4);
    for (int i = 0; i < 8; i++) begin
      if (inc && !load) cnt++;
      if (busy) busy_cycles++;
      if (done) done_cycles++;
      if (i < 5) begin
        total++; if ({load, inc, busy, done} !== 4'b0110) begin bad++; $display("FAIL inc4_drive cyc=%0d got=%b exp=0110", i, {load, inc, busy, done}); end
      end
      if (i == 5) begin
        total++; if ({load, inc, busy, done} !== 4'b0001) begin bad++; $display("FAIL inc4_done got=%b exp=0001", {load, inc, busy, done}); end
      end
      step();
    end
    total++; if (cnt !== 5) begin bad++; $display("FAIL inc4_counter got=%0d exp=5", cnt); end
    total++; if (busy_cycles !== 5) begin bad++; $display("FAIL inc4_busy_cycles got=%0d exp=5", busy_cycles); end
    total++; if (done_cycles !== 1) begin bad++; $display("FAIL inc4_done_count got=%0d exp=1", done_cycles); end
  endtask

  task automatic test_ldinc15();
    int both = 0;
    send(2'b11, 4'd15);
    for (int i = 0; i < 20; i++) begin
      if (load && inc && busy) both++;
      if (i == 16) begin
        total++; if ({load, inc, busy, done} !== 4'b0001) begin bad++; $display("FAIL ldinc15_end got=%b exp=0001", {load, inc, busy, done}); end
      end
      if (i == 17) begin
        total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL ldinc15_no_wrap got=%b exp=00", {busy, done}); end
      end
      step();
    end
    total++; if (both !== 16) begin bad++; $display("FAIL ldinc15_cycles got=%0d exp=16", both); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] obs [8];
    logic [3:0] exp_v [8];
    int sent = 0;
    logic fire;
`ifdef CNT8_CMD_PREFETCH_EN
    exp_v = '{4'b1010, 4'b0111, 4'b0110, 4'b0110, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
`else
    exp_v = '{4'b1010, 4'b0001, 4'b0110, 4'b0110, 4'b0110, 4'b0001, 4'b0000, 4'b0000};
`endif
    cif.cmd_valid = 1'b1;
    cif.cmd_op    = 2'b01;
    cif.cmd_len   = 4'd0;
    for (int i = 0; i < 8; i++) begin
      fire = cif.cmd_valid & cif.cmd_ready;
      step();
      if (fire) begin
        sent++;
        if (sent == 1) begin
          cif.cmd_op  = 2'b10;
          cif.cmd_len = 4'd2;
        end else begin
          cif.cmd_valid = 1'b0;
        end
      end
      obs[i] = {load, inc, busy, done};
    end
    cif.cmd_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      total++; if (obs[i] !== exp_v[i]) begin bad++; $display("FAIL b2b cyc=%0d got=%b exp=%b", i, obs[i], exp_v[i]); end
    end
    total++; if (sent !== 2) begin bad++; $display("FAIL b2b_accepts got=%0d exp=2", sent); end
  endtask

  task automatic test_abort();
    send(2'b10, 4'd7);
    total++; if (inc !== 1'b1) begin bad++; $display("FAIL abort_first got=%b exp=1", inc); end
    step();
    total++; if (inc !== 1'b1) begin bad++; $display("FAIL abort_second got=%b exp=1", inc); end
    abort         = 1'b1;
    cif.cmd_valid = 1'b1;
    cif.cmd_op    = 2'b01;
    cif.cmd_len   = 4'd3;
    #1;
    total++; if (cif.cmd_ready !== 1'b0) begin bad++; $display("FAIL abort_ready got=%b exp=0", cif.cmd_ready); end
    step();
    abort         = 1'b0;
    cif.cmd_valid = 1'b0;
    total++; if ({load, inc, busy, done} !== 4'b0000) begin bad++; $display("FAIL abort_outs got=%b exp=0000", {load, inc, busy, done}); end
    step();
    total++; if ({load, inc, busy, done} !== 4'b0000) begin bad++; $display("FAIL abort_dropped got=%b exp=0000", {load, inc, busy, done}); end
  endtask

  task automatic test_reset_mid_run();
    send(2'b10, 4'd5);
    step();
    step();
    total++; if ({inc, busy} !== 2'b11) begin bad++; $display("FAIL rmid_third got=%b exp=11", {inc, busy}); end
    reset = 1'b1;
    #1;
    total++; if (cif.cmd_ready !== 1'b0) begin bad++; $display("FAIL rmid_ready got=%b exp=0", cif.cmd_ready); end
    step();
    total++; if ({load, inc, busy, done} !== 4'b0000) begin bad++; $display("FAIL rmid_outs got=%b exp=0000", {load, inc, busy, done}); end
    reset = 1'b0;
    #1;
    total++; if (cif.cmd_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready_rel got=%b exp=1", cif.cmd_ready); end
    step();
    total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL rmid_no_done got=%b exp=00", {busy, done}); end
    send(2'b01, 4'd1);
    total++; if ({load, inc, busy, done} !== 4'b1010) begin bad++; $display("FAIL rmid_new1 got=%b exp=1010", {load, inc, busy, done}); end
    step();
    total++; if ({load, inc, busy, done} !== 4'b1010) begin bad++; $display("FAIL rmid_new2 got=%b exp=1010", {load, inc, busy, done}); end
    step();
    total++; if ({load, inc, busy, done} !== 4'b0001) begin bad++; $display("FAIL rmid_new_done got=%b exp=0001", {load, inc, busy, done}); end
  endtask

  initial begin
    reset         = 1'b1;
    abort         = 1'b0;
    cif.cmd_valid = 1'b0;
    cif.cmd_op    = 2'b00;
    cif.cmd_len   = 4'd0;
    test_reset();
    step();
    test_load0();
    test_inc4();
    test_ldinc15();
    test_back_to_back();
    test_abort();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
